network_bank_out: RTL and testbench
===================================

Name: network_bank_out

Overview:
- Return path of the bank interconnect: routes read data from the 4 memory banks back to the 4 butterfly lanes.
- Uses the same per-bank select codes that steered the addresses into the banks.
- Bank j received the address of lane sel_a_j, so lane k must receive q_j where sel_a_j == k, i.e. the inverse permutation.
- Delays the selects internally to match bank read latency and registers the result, giving full-throughput pipelined operation.

Parameters:
- DATA_W, 32, width of one bank read word / lane data word
- RD_LAT, 1, bank read latency in cycles from address-issue cycle to q valid; legal range 1..4

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a read was issued this cycle with the accompanying selects
- sel_a_0, sel_a_1, sel_a_2, sel_a_3  input  2 each  per-bank select codes, identical to those driving the address network this cycle
- q_0, q_1, q_2, q_3  input  DATA_W each  bank read data, valid RD_LAT cycles after in_valid
- err_clr  input  1  synchronous clear of perm_err
- out_valid  output  1  lane data valid
- d_0, d_1, d_2, d_3  output  DATA_W each  lane read data
- perm_err  output  1  sticky flag: a valid transaction carried a non-permutation select set

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, d_0..d_3=0, perm_err=0, all delay-pipeline valid bits and stored selects =0. In-flight transactions are dropped; no out_valid for them after reset release.
- Delay pipeline: RD_LAT stages of {valid, sel_a_0..3}, shifting every cycle unconditionally. Stage 0 captures in_valid and the selects at the edge ending cycle t.
- Route: in cycle t+RD_LAT the delayed selects align with q_0..q_3. For each lane k, the source is the lowest bank index j with delayed sel_a_j == k.
  - If a source exists, the lane word is q_j.
  - If no bank selects lane k, the lane word is 0.
- Output register: loads at the edge ending cycle t+RD_LAT when the delayed valid is 1.
  - out_valid=1 and d_k updated during cycle t+RD_LAT+1.
  - Total latency in_valid to out_valid = RD_LAT+1 cycles.
- When the delayed valid is 0: out_valid=0 the next cycle and d_0..d_3 hold their previous values.
- Throughput: one transaction per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles. Transactions do not interact.
- Permutation check, evaluated on the delayed selects in the routing cycle: invalid if any two sel_a values are equal.
  - If invalid and delayed valid=1, perm_err sets at the same edge that raises out_valid for that transaction. Routing still follows the lowest-index / zero-fill rule above.
  - Selects with delayed valid=0 are never checked.
- perm_err is sticky.
  - err_clr=1 clears it at the next edge.
  - err_clr and a new error in the same cycle: set wins, perm_err=1.
- in_valid held low: pipeline drains, out_valid low after RD_LAT+1 cycles, d holds the last data.

Test Plan:
- Identity, RD_LAT=1: sels=0,1,2,3 with in_valid at cycle 0; q_0..3=A0,B1,C2,D3 at cycle 1 -> out_valid=1 at cycle 2 with d_0..3=A0,B1,C2,D3; perm_err=0.
- Inverse permutation: sels (bank0..3)=2,0,3,1; q=10,11,12,13 -> d_0=11, d_1=13, d_2=10, d_3=12.
- Streaming, RD_LAT=3: in_valid high for 8 consecutive cycles, each with a distinct rotation sel_a_j=(j+n)%4 -> 8 consecutive out_valid cycles starting 4 cycles after the first in_valid, each correctly inverse-rotated; no gaps.
- Invalid permutation: sels=1,1,0,3; q=5,6,7,8 -> d_0=7, d_1=5, d_2=0, d_3=8; perm_err rises with that out_valid and stays high. err_clr pulse -> perm_err=0 next cycle. err_clr coincident with another bad transaction -> perm_err stays 1.
- Idle selects: in_valid=0 with sels=0,0,0,0 -> perm_err stays 0; out_valid stays 0; d holds the prior value.
- Reset mid-flight, RD_LAT=2: in_valid at cycle 0, rst_n low at cycle 1 and released at cycle 2 -> out_valid never asserts for that transaction; d=0, perm_err=0 after reset.

Source files
------------

// File: rtl/network_bank_out.sv
`default_nettype none
// ============================================================================
// network_bank_out : bank-to-lane return network (inverse of the address
// permutation), selects delayed RD_LAT cycles to meet bank read data.
// Revision 1.0
// ============================================================================
module network_bank_out #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        sel_a_0,
    input  logic [1:0]        sel_a_1,
    input  logic [1:0]        sel_a_2,
    input  logic [1:0]        sel_a_3,
    input  logic [DATA_W-1:0] q_0,
    input  logic [DATA_W-1:0] q_1,
    input  logic [DATA_W-1:0] q_2,
    input  logic [DATA_W-1:0] q_3,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] d_0,
    output logic [DATA_W-1:0] d_1,
    output logic [DATA_W-1:0] d_2,
    output logic [DATA_W-1:0] d_3,
    output logic              perm_err
);

    logic              r_vld [RD_LAT];
    logic [7:0]        r_sel [RD_LAT];

    logic              w_vld;
    logic              w_bad;
    logic [1:0]        w_sel  [4];
    logic [DATA_W-1:0] w_q    [4];
    logic [DATA_W-1:0] w_lane [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_sel[i] <= '0;
            end
        end else begin
            r_vld[0] <= in_valid;
            r_sel[0] <= {sel_a_3, sel_a_2, sel_a_1, sel_a_0};
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_sel[i] <= r_sel[i-1];
            end
        end
    end

    assign w_vld    = r_vld[RD_LAT-1];
    assign w_sel[0] = r_sel[RD_LAT-1][1:0];
    assign w_sel[1] = r_sel[RD_LAT-1][3:2];
    assign w_sel[2] = r_sel[RD_LAT-1][5:4];
    assign w_sel[3] = r_sel[RD_LAT-1][7:6];
    assign w_q[0]   = q_0;
    assign w_q[1]   = q_1;
    assign w_q[2]   = q_2;
    assign w_q[3]   = q_3;

    assign w_bad = (w_sel[0] == w_sel[1]) | (w_sel[0] == w_sel[2]) |
                   (w_sel[0] == w_sel[3]) | (w_sel[1] == w_sel[2]) |
                   (w_sel[1] == w_sel[3]) | (w_sel[2] == w_sel[3]);

    // Walking banks from high to low lets the lowest claiming bank win a lane.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane[k] = '0;
        end
        for (int j = 3; j >= 0; j--) begin
            w_lane[w_sel[j]] = w_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d_0       <= '0;
            d_1       <= '0;
            d_2       <= '0;
            d_3       <= '0;
            perm_err  <= 1'b0;
        end else begin
            out_valid <= w_vld;
            if (w_vld) begin
                d_0 <= w_lane[0];
                d_1 <= w_lane[1];
                d_2 <= w_lane[2];
                d_3 <= w_lane[3];
            end
            if (w_vld && w_bad) begin
                perm_err <= 1'b1;
            end else if (err_clr) begin
                perm_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_network_bank_out.sv
`default_nettype none
// ============================================================================
// tb_network_bank_out : scoreboard bench over RD_LAT = 1, 2, 3 instances.
// Revision 1.0
// ============================================================================
module tb_network_bank_out;

    localparam int N   = 2048;
    localparam int NI  = 3;

    typedef struct packed {
        int           cyc;
        logic [127:0] d;
        logic         bad;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  sel_a [4];
    logic        err_clr;
    logic [31:0] qq [NI][4];

    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [7:0]   hs   [N];
    logic [127:0] hq   [N];
    bit           hclr [N];
    exp_t         q_exp [NI][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cyc=%0d actual=%h required=%h", name, inst + 1, cyc, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            logic        ov;
            logic        pe;
            logic [31:0] d0, d1, d2, d3;
            logic [127:0] md;
            logic        me;
            logic        due;
            exp_t        f;

            network_bank_out #(.DATA_W(32), .RD_LAT(gi + 1)) u_dut (
                .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
                .sel_a_0(sel_a[0]), .sel_a_1(sel_a[1]), .sel_a_2(sel_a[2]), .sel_a_3(sel_a[3]),
                .q_0(qq[gi][0]), .q_1(qq[gi][1]), .q_2(qq[gi][2]), .q_3(qq[gi][3]),
                .err_clr(err_clr), .out_valid(ov),
                .d_0(d0), .d_1(d1), .d_2(d2), .d_3(d3), .perm_err(pe)
            );

            always @(negedge clk) begin
                if (cyc >= 0) begin
                    if (!rst_n) begin
                        q_exp[gi].delete();
                        md = '0;
                        me = 1'b0;
                        chk("rst_out_valid", gi, {127'd0, ov}, 128'd0);
                        chk("rst_d", gi, {d3, d2, d1, d0}, 128'd0);
                        chk("rst_perm_err", gi, {127'd0, pe}, 128'd0);
                    end else begin
                        while (q_exp[gi].size() > 0 && q_exp[gi][0].cyc < cyc) begin
                            f = q_exp[gi].pop_front();
                            chk("missed_output", gi, {96'd0, cyc}, {96'd0, f.cyc});
                        end
                        due = (q_exp[gi].size() > 0) && (q_exp[gi][0].cyc == cyc);
                        if (due) f = q_exp[gi].pop_front();
                        if (due && f.bad) me = 1'b1;
                        else if (cyc > 0 && hclr[cyc-1]) me = 1'b0;
                        chk("out_valid", gi, {127'd0, ov}, {127'd0, due});
                        if (due) begin
                            chk("d_route", gi, {d3, d2, d1, d0}, f.d);
                            md = f.d;
                        end else begin
                            chk("d_hold", gi, {d3, d2, d1, d0}, md);
                        end
                        chk("perm_err", gi, {127'd0, pe}, {127'd0, me});
                    end
                end
            end
        end
    endgenerate

    // Reference: lane k takes the first bank (ascending) that names it, else 0.
    function automatic exp_t model(input int c, input int lat);
        exp_t e;
        int   hits [4];
        e.cyc = c + lat + 1;
        e.d   = '0;
        e.bad = 1'b0;
        for (int k = 0; k < 4; k++) hits[k] = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(hs[c][2*j +: 2]) == k) begin
                    e.d[32*k +: 32] = hq[c][32*j +: 32];
                    break;
                end
            end
        end
        for (int j = 0; j < 4; j++) hits[hs[c][2*j +: 2]]++;
        for (int k = 0; k < 4; k++) if (hits[k] != 1) e.bad = 1'b1;
        return e;
    endfunction

    task automatic step(input bit r, input bit v, input logic [7:0] s,
                        input logic [127:0] qd, input bit clr);
        @(posedge clk);
        cyc++;
        #1;
        rst_n    = r;
        in_valid = v;
        err_clr  = clr;
        for (int j = 0; j < 4; j++) sel_a[j] = s[2*j +: 2];
        hs[cyc]   = s;
        hq[cyc]   = qd;
        hclr[cyc] = clr;
        for (int g = 0; g < NI; g++) begin
            for (int j = 0; j < 4; j++) begin
                qq[g][j] = (cyc - g - 1 >= 0) ? hq[cyc-g-1][32*j +: 32] : 32'd0;
            end
            if (v && r) q_exp[g].push_back(model(cyc, g + 1));
        end
    endtask

    function automatic logic [127:0] rnd_q();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rnd_sel();
        logic [1:0] p [4];
        logic [1:0] t;
        int         x;
        if ($urandom_range(3) == 0) return 8'($urandom);
        for (int j = 0; j < 4; j++) p[j] = 2'(j);
        for (int j = 3; j > 0; j--) begin
            x = $urandom_range(j);
            t = p[j]; p[j] = p[x]; p[x] = t;
        end
        return {p[3], p[2], p[1], p[0]};
    endfunction

    initial begin
        cyc = -1; n_chk = 0; n_fail = 0;
        rst_n = 1'b1; in_valid = 1'b0; err_clr = 1'b0;
        for (int j = 0; j < 4; j++) sel_a[j] = 2'd0;
        for (int g = 0; g < NI; g++) for (int j = 0; j < 4; j++) qq[g][j] = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) step(0, 0, 8'h00, 128'd0, 0);
        repeat (2) step(1, 0, 8'h00, rnd_q(), 0);

        // identity, inverse permutation, then a non-permutation
        step(1, 1, {2'd3, 2'd2, 2'd1, 2'd0}, {32'hD3, 32'hC2, 32'hB1, 32'hA0}, 0);
        step(1, 1, {2'd1, 2'd3, 2'd0, 2'd2}, {32'd13, 32'd12, 32'd11, 32'd10}, 0);
        repeat (3) step(1, 0, rnd_sel(), rnd_q(), 0);
        step(1, 1, {2'd3, 2'd0, 2'd1, 2'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 0);
        repeat (6) step(1, 0, 8'h00, rnd_q(), 0);
        step(1, 0, 8'h00, rnd_q(), 1);
        repeat (3) step(1, 0, 8'h00, rnd_q(), 0);
        // bad transaction whose error lands while err_clr is held
        step(1, 1, {2'd2, 2'd2, 2'd2, 2'd2}, rnd_q(), 1);
        repeat (4) step(1, 0, 8'h00, rnd_q(), 1);
        repeat (4) step(1, 0, 8'h00, rnd_q(), 0);

        // streaming rotations
        for (int n = 0; n < 8; n++)
            step(1, 1, {2'((3 + n) % 4), 2'((2 + n) % 4), 2'((1 + n) % 4), 2'(n % 4)}, rnd_q(), 0);
        repeat (6) step(1, 0, 8'h00, rnd_q(), 0);

        for (int i = 0; i < 300; i++)
            step(1, ($urandom_range(9) < 7), rnd_sel(), rnd_q(), ($urandom_range(9) == 0));
        repeat (6) step(1, 0, 8'h00, rnd_q(), 0);

        // reset while a transaction is in flight
        step(1, 1, {2'd0, 2'd1, 2'd2, 2'd3}, rnd_q(), 0);
        step(0, 0, 8'h00, rnd_q(), 0);
        step(1, 0, 8'h00, rnd_q(), 0);
        repeat (6) step(1, 0, 8'h00, rnd_q(), 0);
        for (int i = 0; i < 40; i++)
            step(1, ($urandom_range(1) == 1), rnd_sel(), rnd_q(), ($urandom_range(7) == 0));
        repeat (8) step(1, 0, 8'h00, rnd_q(), 0);

        @(posedge clk);
        for (int g = 0; g < NI; g++)
            chk("drain", g, {96'd0, q_exp[g].size()}, 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
